// File: rtl/spi_ctl_pkg.sv
// Shared types and sizing helpers for the SPI frame sequencer.
package spi_ctl_pkg;

    localparam int W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_DONE,
        ST_GAP
    } state_t;

    // One counter serves both the WAIT timeout and the inter-frame gap.
    function automatic int cnt_width(input int timeout, input int gap);
        int span;
        span = (timeout > gap + 1) ? timeout : gap + 1;
        return (span > 2) ? $clog2(span) : 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the channel that did not own the last frame wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       RESET,
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_update,
    output logic       o_grant,
    output logic       o_any
);

    logic r_last;

    // Reset to ch1 as "last owner" so the first tie goes to ch0.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (RESET) begin
            r_last <= 1'b1;
        end else if (i_update) begin
            r_last <= i_last;
        end
    end

    always_comb begin
        // NOTE: o_grant is defaulted before the case so no request pattern infers a latch.
        o_grant = 1'b0;
        case (i_req)
            2'b10:   o_grant = 1'b1;
            2'b11:   o_grant = ~r_last;
            default: o_grant = 1'b0;
        endcase
    end

    assign o_any = |i_req;

endmodule

// File: rtl/spi_master_sched.sv
// Shares one SPI frame engine between two requesters: grants round-robin, starts the
// frame, waits for LOAD (or a timeout) and hands the received word back with an ack.
module spi_master_sched
    import spi_ctl_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int TIMEOUT = 64,
    parameter int GAP     = 2
) (
    input  logic         clk,
    input  logic         RESET,
    input  logic         req0,
    input  logic [W-1:0] tx0,
    output logic         ack0,
    output logic [W-1:0] rx0,
    output logic         err0,
    input  logic         req1,
    input  logic [W-1:0] tx1,
    output logic         ack1,
    output logic [W-1:0] rx1,
    output logic         err1,
    output logic         st,
    output logic [W-1:0] MTX_DAT,
    input  logic         LOAD,
    input  logic [W-1:0] MRX_DAT,
    output logic         busy,
    output logic         owner
);

    localparam int            CW       = cnt_width(TIMEOUT, GAP);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_owner;
    logic          r_err_pend;
    logic [W-1:0]  r_mtx;
    logic [W-1:0]  r_rx0;
    logic [W-1:0]  r_rx1;
    logic          w_grant;
    logic          w_any;
    logic          w_update;
    logic          w_timeout;

    assign w_update  = (r_state == ST_DONE);
    assign w_timeout = (r_cnt == TO_LAST);

    rr_arb2 u_arb (
        .clk      (clk),
        .RESET    (RESET),
        .i_req    ({req1, req0}),
        .i_last   (r_owner),
        .i_update (w_update),
        .o_grant  (w_grant),
        .o_any    (w_any)
    );

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        st     = 1'b0;
        ack0   = 1'b0;
        ack1   = 1'b0;
        err0   = 1'b0;
        err1   = 1'b0;
        busy   = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE:  if (w_any) w_next = ST_START;
            ST_START: begin
                st     = 1'b1;
                w_next = ST_WAIT;
            end
            // LOAD is checked alongside the timeout so a coincident LOAD still succeeds.
            ST_WAIT:  if (LOAD || w_timeout) w_next = ST_DONE;
            ST_DONE: begin
                ack0   = ~r_owner;
                ack1   = r_owner;
                err0   = ~r_owner & r_err_pend;
                err1   = r_owner & r_err_pend;
                w_next = (GAP > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP:   if (r_cnt == GAP_LAST) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_cnt      <= '0;
            r_owner    <= 1'b0;
            r_err_pend <= 1'b0;
            r_mtx      <= '0;
            r_rx0      <= '0;
            r_rx1      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_grant;
                        r_mtx   <= w_grant ? tx1 : tx0;
                    end
                end
                ST_START: begin
                    r_cnt      <= '0;
                    r_err_pend <= 1'b0;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (LOAD) begin
                        if (r_owner) r_rx1 <= MRX_DAT;
                        else         r_rx0 <= MRX_DAT;
                        r_err_pend <= 1'b0;
                    end else if (w_timeout) begin
                        r_err_pend <= 1'b1;
                    end
                end
                ST_DONE: r_cnt <= '0;
                ST_GAP:  r_cnt <= r_cnt + CW'(1);
                default: r_cnt <= '0;
            endcase
        end
    end

    assign MTX_DAT = r_mtx;
    assign rx0     = r_rx0;
    assign rx1     = r_rx1;
    assign owner   = r_owner;

endmodule

// File: tb/tb_spi_master_sched.sv
// Scoreboard bench for spi_master_sched with a behavioural SPI engine answering each st.
module tb_spi_master_sched;

    localparam int W       = 16;
    localparam int TIMEOUT = 64;
    localparam int GAP     = 2;

    typedef struct { int cyc; logic [W-1:0] tx; logic own; } st_ev_t;
    typedef struct { int cyc; logic a0; logic a1; logic e0; logic e1; logic [W-1:0] rx0; logic [W-1:0] rx1; } ack_ev_t;
    typedef struct { logic ch; logic [W-1:0] tx; logic [W-1:0] rx; logic err; } exp_t;

    logic         clk = 1'b0;
    logic         RESET = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] tx0 = '0, tx1 = '0;
    logic         LOAD = 1'b0;
    logic [W-1:0] MRX_DAT = '0;
    logic         ack0, ack1, err0, err1, st, busy, owner;
    logic [W-1:0] rx0, rx1, MTX_DAT;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_double = 0;

    st_ev_t       st_q[$];
    ack_ev_t      ack_q[$];
    exp_t         exp_q[$];
    logic [W-1:0] eng_rx_q[$];
    logic [W-1:0] mdl_rx[2];

    int           eng_delay = 0;
    int           load_at = 0;
    bit           load_pend = 1'b0;
    logic [W-1:0] eng_word = '0;
    int           stray_at = -1;
    logic [W-1:0] stray_data = '0;
    st_ev_t       m_sev;
    ack_ev_t      m_aev;

    spi_master_sched #(.W(W), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk(clk), .RESET(RESET),
        .req0(req0), .tx0(tx0), .ack0(ack0), .rx0(rx0), .err0(err0),
        .req1(req1), .tx1(tx1), .ack1(ack1), .rx1(rx1), .err1(err1),
        .st(st), .MTX_DAT(MTX_DAT), .LOAD(LOAD), .MRX_DAT(MRX_DAT),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor and engine model: records st/ack events and drives LOAD for the coming edge.
    always @(negedge clk) begin
        if (st) begin
            m_sev.cyc = cyc; m_sev.tx = MTX_DAT; m_sev.own = owner;
            st_q.push_back(m_sev);
            eng_word = (eng_rx_q.size() > 0) ? eng_rx_q.pop_front() : '0;
            if (eng_delay > 0) begin
                load_at   = cyc + eng_delay;
                load_pend = 1'b1;
            end
        end
        if (ack0 || ack1) begin
            m_aev.cyc = cyc; m_aev.a0 = ack0; m_aev.a1 = ack1; m_aev.e0 = err0; m_aev.e1 = err1;
            m_aev.rx0 = rx0; m_aev.rx1 = rx1;
            ack_q.push_back(m_aev);
            if (ack0 && ack1) n_double++;
        end
        LOAD    = 1'b0;
        MRX_DAT = 16'hC0DE;
        if (load_pend && cyc == load_at) begin
            LOAD      = 1'b1;
            MRX_DAT   = eng_word;
            load_pend = 1'b0;
        end else if (cyc == stray_at) begin
            LOAD    = 1'b1;
            MRX_DAT = stray_data;
        end
    end

    task automatic push_exp(input logic ch, input logic [W-1:0] tx, input logic [W-1:0] resp, input logic err);
        exp_t e;
        e.ch = ch; e.tx = tx; e.err = err;
        e.rx = err ? mdl_rx[ch] : resp;
        if (!err) mdl_rx[ch] = resp;
        exp_q.push_back(e);
        eng_rx_q.push_back(resp);
    endtask

    task automatic clear_q();
        st_q.delete(); ack_q.delete(); exp_q.delete(); eng_rx_q.delete();
    endtask

    task automatic wait_st(input int n, input int budget);
        for (int i = 0; i < budget && st_q.size() < n; i++) @(posedge clk);
    endtask

    task automatic wait_ack(input int n, input int budget);
        for (int i = 0; i < budget && ack_q.size() < n; i++) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        RESET = 1'b1; load_pend = 1'b0; stray_at = -1;
        @(negedge clk);
        RESET = 1'b0;
        mdl_rx[0] = '0; mdl_rx[1] = '0;
        clear_q();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({st, ack0, ack1, err0, err1, busy, owner} !== 7'b0) begin
            n_bad++; $display("FAIL reset_ctl: got %b, expected 0000000", {st, ack0, ack1, err0, err1, busy, owner});
        end
        n_cmp++;
        if ((MTX_DAT | rx0 | rx1) !== '0) begin
            n_bad++; $display("FAIL reset_data: got mtx=%h rx0=%h rx1=%h, expected all 0", MTX_DAT, rx0, rx1);
        end
        RESET = 1'b0;
        mdl_rx[0] = '0; mdl_rx[1] = '0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || st_q.size() != 0) begin
            n_bad++; $display("FAIL reset_idle: got busy=%b starts=%0d, expected 0/0", busy, st_q.size());
        end
    endtask

    task automatic test_single_ch0();
        int rc; st_ev_t s; ack_ev_t a; exp_t e;
        clear_q(); eng_delay = 20;
        @(negedge clk);
        rc = cyc; req0 = 1'b1; tx0 = 16'h1234;
        push_exp(1'b0, 16'h1234, 16'h5678, 1'b0);
        wait_st(1, 10);
        n_cmp++;
        if (st_q.size() != 1) begin n_bad++; $display("FAIL single_st: got %0d starts, expected 1", st_q.size()); return; end
        @(negedge clk);
        req0 = 1'b0;
        wait_ack(1, 60);
        n_cmp++;
        if (ack_q.size() != 1) begin n_bad++; $display("FAIL single_ack: got %0d acks, expected 1", ack_q.size()); return; end
        s = st_q.pop_front(); a = ack_q.pop_front(); e = exp_q.pop_front();
        n_cmp++;
        if (s.cyc != rc + 1) begin n_bad++; $display("FAIL single_st_lat: got cycle %0d, expected %0d", s.cyc, rc + 1); end
        n_cmp++;
        if ({s.own, s.tx} !== {e.ch, e.tx}) begin n_bad++; $display("FAIL single_tx: got own=%b tx=%h, expected %b/%h", s.own, s.tx, e.ch, e.tx); end
        n_cmp++;
        if (a.cyc != s.cyc + 21) begin n_bad++; $display("FAIL single_ack_lat: got cycle %0d, expected %0d", a.cyc, s.cyc + 21); end
        n_cmp++;
        if ({a.a1, a.a0, a.e1, a.e0} !== 4'b0100 || a.rx0 !== e.rx) begin
            n_bad++; $display("FAIL single_result: got ack/err=%b rx0=%h, expected 0100/%h", {a.a1, a.a0, a.e1, a.e0}, a.rx0, e.rx);
        end
        repeat (30) @(negedge clk);
        n_cmp++;
        if (ack_q.size() != 0 || st_q.size() != 0 || rx0 !== 16'h5678) begin
            n_bad++; $display("FAIL single_after: got acks=%0d starts=%0d rx0=%h, expected 0/0/5678", ack_q.size(), st_q.size(), rx0);
        end
    endtask

    task automatic test_simultaneous();
        int rc; st_ev_t s[2]; ack_ev_t a; exp_t e; logic [1:0] ea, ee;
        do_reset(); eng_delay = 5;
        @(negedge clk);
        rc = cyc; req0 = 1'b1; req1 = 1'b1; tx0 = 16'hAAAA; tx1 = 16'h5555;
        push_exp(1'b0, 16'hAAAA, 16'h1111, 1'b0);
        push_exp(1'b1, 16'h5555, 16'h2222, 1'b0);
        wait_st(1, 10);
        @(negedge clk);
        req0 = 1'b0;
        wait_st(2, 60);
        @(negedge clk);
        req1 = 1'b0;
        wait_ack(2, 60);
        n_cmp++;
        if (st_q.size() != 2 || ack_q.size() != 2) begin
            n_bad++; $display("FAIL sim_count: got starts=%0d acks=%0d, expected 2/2", st_q.size(), ack_q.size()); return;
        end
        s[0] = st_q.pop_front(); s[1] = st_q.pop_front();
        n_cmp++;
        if (s[0].cyc != rc + 1) begin n_bad++; $display("FAIL sim_st0_lat: got %0d, expected %0d", s[0].cyc, rc + 1); end
        for (int i = 0; i < 2; i++) begin
            a = ack_q.pop_front(); e = exp_q.pop_front();
            ea = e.ch ? 2'b10 : 2'b01;
            ee = e.err ? ea : 2'b00;
            n_cmp++;
            if ({s[i].own, s[i].tx} !== {e.ch, e.tx}) begin n_bad++; $display("FAIL sim_tx%0d: got own=%b tx=%h, expected %b/%h", i, s[i].own, s[i].tx, e.ch, e.tx); end
            n_cmp++;
            if ({a.a1, a.a0, a.e1, a.e0} !== {ea, ee} || (e.ch ? a.rx1 : a.rx0) !== e.rx) begin
                n_bad++; $display("FAIL sim_ack%0d: got ack/err=%b rx=%h, expected %b/%h", i, {a.a1, a.a0, a.e1, a.e0}, e.ch ? a.rx1 : a.rx0, {ea, ee}, e.rx);
            end
            if (i == 0) begin
                n_cmp++;
                if (s[1].cyc != a.cyc + GAP + 2) begin n_bad++; $display("FAIL sim_gap: got st at %0d, expected %0d", s[1].cyc, a.cyc + GAP + 2); end
            end
        end
    endtask

    task automatic test_fairness();
        st_ev_t s; ack_ev_t a; exp_t e; logic [1:0] ea;
        clear_q(); eng_delay = 3;
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; tx0 = 16'h0C00; tx1 = 16'h0C01;
        for (int i = 0; i < 6; i++) push_exp(1'(i % 2), (i % 2 == 1) ? 16'h0C01 : 16'h0C00, 16'hF000 + 16'(i), 1'b0);
        wait_st(6, 200);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        wait_ack(6, 100);
        n_cmp++;
        if (st_q.size() != 6 || ack_q.size() != 6) begin
            n_bad++; $display("FAIL fair_count: got starts=%0d acks=%0d, expected 6/6", st_q.size(), ack_q.size()); return;
        end
        for (int i = 0; i < 6; i++) begin
            s = st_q.pop_front(); a = ack_q.pop_front(); e = exp_q.pop_front();
            ea = e.ch ? 2'b10 : 2'b01;
            n_cmp++;
            if (s.own !== e.ch || s.tx !== e.tx || {a.a1, a.a0} !== ea) begin
                n_bad++; $display("FAIL fair_owner%0d: got own=%b tx=%h ack=%b, expected %b/%h/%b", i, s.own, s.tx, {a.a1, a.a0}, e.ch, e.tx, ea);
            end
            n_cmp++;
            if ((e.ch ? a.rx1 : a.rx0) !== e.rx || {a.e1, a.e0} !== 2'b00) begin
                n_bad++; $display("FAIL fair_rx%0d: got rx=%h err=%b, expected %h/00", i, e.ch ? a.rx1 : a.rx0, {a.e1, a.e0}, e.rx);
            end
        end
    endtask

    task automatic test_timeout();
        st_ev_t s; ack_ev_t a; exp_t e;
        for (int k = 0; k < 2; k++) begin
            clear_q();
            repeat (6) @(negedge clk);
            eng_delay = (k == 0) ? 0 : 4;
            req0 = 1'b1; tx0 = (k == 0) ? 16'h0BAD : 16'h0600;
            push_exp(1'b0, tx0, 16'hBEEF, (k == 0));
            wait_st(1, 10);
            @(negedge clk);
            req0 = 1'b0;
            wait_ack(1, 2 * TIMEOUT);
            n_cmp++;
            if (st_q.size() != 1 || ack_q.size() != 1) begin
                n_bad++; $display("FAIL tmo%0d_count: got starts=%0d acks=%0d, expected 1/1", k, st_q.size(), ack_q.size()); return;
            end
            s = st_q.pop_front(); a = ack_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (a.cyc != s.cyc + ((k == 0) ? TIMEOUT + 1 : 5)) begin
                n_bad++; $display("FAIL tmo%0d_lat: got ack at %0d, expected %0d", k, a.cyc, s.cyc + ((k == 0) ? TIMEOUT + 1 : 5));
            end
            n_cmp++;
            if ({a.a1, a.a0, a.e1, a.e0} !== {3'b010, e.err} || a.rx0 !== e.rx) begin
                n_bad++; $display("FAIL tmo%0d_result: got ack/err=%b rx0=%h, expected %b/%h", k, {a.a1, a.a0, a.e1, a.e0}, a.rx0, {3'b010, e.err}, e.rx);
            end
        end
    endtask

    task automatic test_stray_load();
        st_ev_t s; ack_ev_t a; exp_t e;
        clear_q();
        repeat (6) @(negedge clk);
        stray_at = cyc + 1; stray_data = 16'hDEAD;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (ack_q.size() != 0 || busy !== 1'b0 || rx0 !== mdl_rx[0] || rx1 !== mdl_rx[1]) begin
            n_bad++; $display("FAIL stray_load: got acks=%0d busy=%b rx0=%h rx1=%h, expected 0/0/%h/%h", ack_q.size(), busy, rx0, rx1, mdl_rx[0], mdl_rx[1]);
        end
        eng_delay = TIMEOUT;
        req0 = 1'b1; tx0 = 16'h0707;
        push_exp(1'b0, 16'h0707, 16'hA5A5, 1'b0);
        wait_st(1, 10);
        @(negedge clk);
        req0 = 1'b0;
        wait_ack(1, 2 * TIMEOUT);
        n_cmp++;
        if (st_q.size() != 1 || ack_q.size() != 1) begin
            n_bad++; $display("FAIL edge_count: got starts=%0d acks=%0d, expected 1/1", st_q.size(), ack_q.size()); return;
        end
        s = st_q.pop_front(); a = ack_q.pop_front(); e = exp_q.pop_front();
        n_cmp++;
        if (a.cyc != s.cyc + TIMEOUT + 1 || {a.a1, a.a0, a.e1, a.e0} !== 4'b0100 || a.rx0 !== e.rx) begin
            n_bad++; $display("FAIL edge_load: got cyc=%0d ack/err=%b rx0=%h, expected %0d/0100/%h", a.cyc, {a.a1, a.a0, a.e1, a.e0}, a.rx0, s.cyc + TIMEOUT + 1, e.rx);
        end
    endtask

    task automatic test_reset_midframe();
        int rr; ack_ev_t a; exp_t e;
        clear_q();
        repeat (6) @(negedge clk);
        eng_delay = 30;
        eng_rx_q.push_back(16'h7777);
        req0 = 1'b1; tx0 = 16'h0101;
        wait_st(1, 10);
        repeat (10) @(negedge clk);
        rr = cyc; RESET = 1'b1; load_pend = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({st, ack0, ack1, err0, err1, busy, owner} !== 7'b0 || (MTX_DAT | rx0 | rx1) !== '0) begin
            n_bad++; $display("FAIL midrst_outputs: got ctl=%b mtx=%h rx0=%h rx1=%h, expected all 0", {st, ack0, ack1, err0, err1, busy, owner}, MTX_DAT, rx0, rx1);
        end
        RESET = 1'b0;
        mdl_rx[0] = '0; mdl_rx[1] = '0;
        eng_delay = 5;
        push_exp(1'b0, 16'h0101, 16'h4242, 1'b0);
        wait_st(2, 10);
        n_cmp++;
        if (st_q.size() != 2) begin n_bad++; $display("FAIL midrst_regrant: got %0d starts, expected 2", st_q.size()); return; end
        n_cmp++;
        if (st_q[1].cyc != rr + 2) begin n_bad++; $display("FAIL midrst_st_lat: got %0d, expected %0d", st_q[1].cyc, rr + 2); end
        @(negedge clk);
        req0 = 1'b0;
        wait_ack(1, 40);
        repeat (40) @(negedge clk);
        n_cmp++;
        if (ack_q.size() != 1) begin n_bad++; $display("FAIL midrst_acks: got %0d acks, expected 1", ack_q.size()); return; end
        a = ack_q.pop_front(); e = exp_q.pop_front();
        n_cmp++;
        if ({a.a1, a.a0, a.e1, a.e0} !== 4'b0100 || a.rx0 !== e.rx || a.rx1 !== mdl_rx[1]) begin
            n_bad++; $display("FAIL midrst_result: got ack/err=%b rx0=%h rx1=%h, expected 0100/%h/%h", {a.a1, a.a0, a.e1, a.e0}, a.rx0, a.rx1, e.rx, mdl_rx[1]);
        end
    endtask

    initial begin
        test_reset();
        test_single_ch0();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_stray_load();
        test_reset_midframe();
        n_cmp++;
        if (n_double != 0) begin n_bad++; $display("FAIL double_ack: got %0d cycles with both acks, expected 0", n_double); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by time limit, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_master_sched.md
Name: spi_master_sched

Overview:
Sequencer and two-way arbiter that shares one 16-bit SPI master frame engine between two requesters. It grants requesters round-robin, drives the engine's `st` start pulse and `MTX_DAT`, and captures `MRX_DAT` on frame completion. It returns the received word to the owning requester with a one-cycle `ack`. It sits between system-side clients and the existing SPI master; `SCLK`, `MOSI` and `MISO` stay inside the engine.

Parameters:
W, 16, frame/data width; matches the engine's `MTX_DAT`/`MRX_DAT` width.
TIMEOUT, 64, max clk cycles in WAIT before the frame is declared failed; must be ≥ 2.
GAP, 2, idle clk cycles forced between consecutive frames; 0 allowed.

Ports:
clk  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
req0  in  1  channel 0 request, level
tx0  in  W  channel 0 word to send
ack0  out  1  channel 0 done pulse, 1 cycle
rx0  out  W  channel 0 received word, valid from ack0
err0  out  1  channel 0 timeout flag, pulses with ack0
req1  in  1  channel 1 request, level
tx1  in  W  channel 1 word to send
ack1  out  1  channel 1 done pulse
rx1  out  W  channel 1 received word
err1  out  1  channel 1 timeout flag
st  out  1  start pulse to SPI engine, 1 cycle
MTX_DAT  out  W  word to SPI engine, stable from st until DONE
LOAD  in  1  engine end-of-frame pulse, 1 cycle; MRX_DAT valid in same cycle
MRX_DAT  in  W  engine received word
busy  out  1  high in every state except IDLE
owner  out  1  channel owning the current or last frame

Behaviour:
- Reset (RESET=1 at an edge):
  - state=IDLE.
  - st, ack0/1, err0/1, busy, owner = 0; MTX_DAT, rx0, rx1 = 0.
  - Round-robin pointer favours ch0; counters = 0.
  - Reset mid-frame aborts with no ack; the engine shares the same RESET.
- States: IDLE, START, WAIT, DONE, GAP.
- IDLE:
  - If req0|req1: choose the winner, set owner, latch the winner's tx into MTX_DAT, go to START.
  - Arbitration: only one request → that channel. Both → the channel ≠ the last owner. First grant after reset with both → ch0.
- START: st=1 for exactly this cycle; clear timeout counter; go to WAIT.
- WAIT:
  - Timeout counter increments each cycle.
  - LOAD=1 → rx[owner] ← MRX_DAT, go to DONE (err=0).
  - Counter reaches TIMEOUT-1 without LOAD → rx[owner] unchanged, set pending err, go to DONE.
  - LOAD in the same cycle as timeout → LOAD wins, no err.
- DONE:
  - ack[owner]=1 for one cycle; err[owner]=pending err.
  - Update round-robin pointer.
  - GAP>0 → GAP, else IDLE.
- GAP: count GAP cycles, then IDLE. Requests seen during GAP are held until IDLE.
- Latency:
  - Request sampled in IDLE at edge N → st high in cycle N+1.
  - LOAD in cycle M → ack in cycle M+1.
  - Back-to-back (both requesting, GAP=0): the next st follows ack by 2 cycles.
- LOAD outside WAIT is ignored (no capture, no ack).
- Requester rules:
  - Hold req and tx stable until ack.
  - Dropping req before grant cancels the request.
  - Dropping req after grant does not cancel; the frame completes and ack is still issued.
  - Req held high after ack → new request.
- rx0/rx1 hold their value until the next successful frame of that channel.
- st is never asserted while busy is high outside START.

Decomposition:
- Shared package spi_ctl_pkg:
  - State enum (IDLE, START, WAIT, DONE, GAP).
  - W default.
  - Counter-width function clog2(max(TIMEOUT, GAP+1)).
- One sub-module, rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], last owner, update strobe.
  - Outputs: grant index, any-request flag.
- FSM, counters and data registers stay in spi_master_sched.

Test Plan:
- Single ch0: req0=1, tx0=16'h1234; engine model returns LOAD 20 cycles after st with MRX_DAT=16'h5678 → st 1 cycle after req, MTX_DAT=16'h1234, ack0 1 cycle after LOAD, rx0=16'h5678, err0=0, ack1 never.
- Simultaneous after reset: req0=req1=1, tx0=16'hAAAA, tx1=16'h5555 → frames in order ch0 then ch1; MTX_DAT=16'hAAAA then 16'h5555; second st exactly 1+GAP+1 cycles after ack0; owner 0 then 1.
- Fairness: both held high for 6 frames → owner alternates 0,1,0,1,0,1; no channel served twice in a row.
- Timeout: TIMEOUT=64, engine never pulses LOAD → ack0 and err0 together exactly 64 cycles after st+1; rx0 keeps its old value; next request proceeds normally.
- Stray/edge LOAD: LOAD pulsed in IDLE → no ack and no rx change. LOAD at the timeout cycle → success, err0=0.
- Reset mid-WAIT: RESET=1 for 1 cycle during a frame → all outputs 0, state IDLE, no ack; a pending req0 is granted st 1 cycle after RESET deasserts.
